// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the wrapping down-counter
//
// Purpose: implementation selector enum and an all-ones helper, used by the
// counter RTL and its testbench.
package counter_pkg;

    // Selects the decrement datapath of counter_wrap_down.
    typedef enum logic [0:0] {
        CNT_IMP_OPERATOR = 1'b0,
        CNT_IMP_BORROW   = 1'b1
    } counter_imp_t;

    // Largest value representable in 'width' bits (2^width - 1).
    function automatic int counter_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/counter_wrap_down_dec.sv
// rtl/counter_wrap_down_dec.sv - combinational decrement-by-one with borrow-out
//
// Purpose: WIDTH-bit decrementer built as an explicit ripple borrow chain.
// Ports:
//   a      in   WIDTH  operand
//   diff   out  WIDTH  (a - 1) mod 2^WIDTH
//   borrow out  1      high when a == 0 (the subtraction wrapped)
module counter_wrap_down_dec
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // chain[i] is the borrow into bit i; subtracting one injects a borrow at bit 0.
    logic [WIDTH:0] chain;

    assign chain[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]      = a[i] ^ chain[i];
        // A borrow propagates only through bits that are zero.
        assign chain[i + 1] = ~a[i] & chain[i];
    end

    // Borrow out of the top bit means every bit was zero.
    assign borrow = chain[WIDTH];

endmodule

// File: rtl/counter_wrap_down.sv
// rtl/counter_wrap_down.sv - wrapping down-counter with load, zero and borrow flags
//
// Purpose: decrementing counter with synchronous load; registered zero flag
// and a one-cycle borrow pulse on decrement-from-zero.
// Optional feature macro: COUNTER_WRAP_DOWN_RELOAD_EN (auto-reload from the
// last loaded value instead of wrapping to all ones).
// Ports:
//   clk  in   1      clock, rising edge
//   rst  in   1      synchronous active-high reset
//   ena  in   1      decrement enable
//   ld   in   1      synchronous load, priority over ena
//   val  in   WIDTH  load value
//   cnt  out  WIDTH  counter value
//   zro  out  1      cnt == 0
//   brw  out  1      one-cycle pulse on decrement from zero
module counter_wrap_down
    import counter_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             ld,
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] cnt,
    output logic             zro,
    output logic             brw
);

    if (WIDTH < 1) begin : g_bad_width
        $error("counter_wrap_down: WIDTH must be at least 1");
    end
    if (IMPLEMENTATION != int'(CNT_IMP_OPERATOR) &&
        IMPLEMENTATION != int'(CNT_IMP_BORROW)) begin : g_bad_imp
        $error("counter_wrap_down: IMPLEMENTATION must be 0 or 1");
    end

    // Decremented value and "cnt was zero" indication from the chosen datapath.
    logic [WIDTH-1:0] dec;
    logic             dec_brw;

    if (IMPLEMENTATION == int'(CNT_IMP_BORROW)) begin : g_borrow
        counter_wrap_down_dec #(
            .WIDTH (WIDTH)
        ) u_dec (
            .a      (cnt),
            .diff   (dec),
            .borrow (dec_brw)
        );
    end else begin : g_operator
        assign dec     = cnt - WIDTH'(1);
        assign dec_brw = (cnt == '0);
    end

`ifdef COUNTER_WRAP_DOWN_RELOAD_EN
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            zro    <= 1'b1;
            brw    <= 1'b0;
            reload <= '0;
        end else if (ld) begin
            cnt    <= val;
            zro    <= (val == '0);
            brw    <= 1'b0;
            reload <= val;
        end else if (ena) begin
            brw <= dec_brw;
            if (dec_brw) begin
                // Period restarts from the last loaded value.
                cnt <= reload;
                zro <= (reload == '0);
            end else begin
                cnt <= dec;
                zro <= (dec == '0);
            end
        end else begin
            brw <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            zro <= 1'b1;
            brw <= 1'b0;
        end else if (ld) begin
            cnt <= val;
            zro <= (val == '0);
            brw <= 1'b0;
        end else if (ena) begin
            // dec is all ones after a wrap, so the zero test covers both cases.
            cnt <= dec;
            zro <= (dec == '0);
            brw <= dec_brw;
        end else begin
            brw <= 1'b0;
        end
    end
`endif

endmodule
